// File: rtl/mwave_timer_ctrl.sv
// Microwave oven controller: door/start/cancel FSM, cook countdown, power duty, bell.
// Optional child lock via MWAVE_CHILD_LOCK_EN (adds lock_key input, locked output).
module mwave_timer_ctrl #(
    parameter int TIME_W       = 8,
    parameter int CLK_PER_TICK = 100,
    parameter int PWR_W        = 2,
    parameter int BELL_TICKS   = 3,
    parameter int ADD_SEC      = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              door,
    input  logic              start,
    input  logic              cancel,
    input  logic [TIME_W-1:0] time_in,
    input  logic [PWR_W-1:0]  power_in,
`ifdef MWAVE_CHILD_LOCK_EN
    input  logic              lock_key,
    output logic              locked,
`endif
    output logic              heat,
    output logic              light,
    output logic              bell,
    output logic [TIME_W-1:0] remaining,
    output logic              busy
);

    localparam int PRE_W  = $clog2(CLK_PER_TICK);
    localparam int BCNT_W = $clog2(BELL_TICKS + 1);
    localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(CLK_PER_TICK - 1);
    localparam logic [BCNT_W-1:0] BELL_LAST = BCNT_W'(BELL_TICKS - 1);
    localparam logic [TIME_W:0]   ADD_V     = (TIME_W + 1)'(ADD_SEC);
    localparam logic [TIME_W-1:0] T_MAX     = '1;
    localparam logic [TIME_W-1:0] T_ONE     = TIME_W'(1);

    typedef enum logic [2:0] {IDLE, OPEN, COOK, PAUSE, BELL} state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   rem_q, rem_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [PWR_W-1:0]    phase_q, phase_d;
    logic [PWR_W-1:0]    pwr_q, pwr_d;
    logic                heat_q, light_q, bell_q, busy_q;
    logic                heat_d, light_d, bell_d, busy_d;
    logic                start_ok, tick;
    logic [PRE_W-1:0]    presc_inc;
    logic [TIME_W:0]     sum;
    logic [TIME_W-1:0]   add_sat;

`ifdef MWAVE_CHILD_LOCK_EN
    logic lock_prev_q, locked_q;
    assign start_ok = start & ~locked_q;
    assign locked   = locked_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_prev_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            lock_prev_q <= lock_key;
            if (lock_key && !lock_prev_q)
                locked_q <= ~locked_q;
        end
    end
`else
    assign start_ok = start;
`endif

    assign tick      = (presc_q == PRE_MAX);
    assign presc_inc = tick ? '0 : presc_q + 1'b1;
    assign sum       = {1'b0, rem_q} + ADD_V;
    // Saturate before any same-cycle decrement
    assign add_sat   = sum[TIME_W] ? T_MAX : sum[TIME_W-1:0];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        presc_d = presc_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        pwr_d   = pwr_q;
        unique case (state_q)
            IDLE: begin
                if (door) begin
                    state_d = OPEN;
                end else if (start_ok && time_in != '0) begin
                    state_d = COOK;
                    rem_d   = time_in;
                    pwr_d   = power_in;
                    presc_d = '0;
                    phase_d = '0;
                end
            end
            OPEN: begin
                if (!door) state_d = IDLE;
            end
            COOK: begin
                phase_d = phase_q + 1'b1;
                if (door) begin
                    state_d = PAUSE;
                end else if (cancel) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else begin
                    presc_d = presc_inc;
                    if (start_ok) begin
                        rem_d = tick ? add_sat - 1'b1 : add_sat;
                    end else if (tick) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == T_ONE) begin
                            state_d = BELL;
                            bcnt_d  = '0;
                        end
                    end
                end
            end
            PAUSE: begin
                if (cancel) begin
                    state_d = door ? OPEN : IDLE;
                    rem_d   = '0;
                end else if (!door) begin
                    state_d = COOK;
                end
            end
            BELL: begin
                if (door) begin
                    state_d = OPEN;
                end else begin
                    presc_d = presc_inc;
                    if (tick) bcnt_d = bcnt_q + 1'b1;
                    if (cancel || (tick && bcnt_q == BELL_LAST))
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign heat_d  = (state_d == COOK) && (phase_d <= pwr_d);
    assign light_d = (state_d == COOK) || (state_d == PAUSE) || (state_d == OPEN);
    assign bell_d  = (state_d == BELL);
    assign busy_d  = (state_d == COOK) || (state_d == PAUSE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            presc_q <= '0;
            bcnt_q  <= '0;
            phase_q <= '0;
            pwr_q   <= '0;
            heat_q  <= 1'b0;
            light_q <= 1'b0;
            bell_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            pwr_q   <= pwr_d;
            heat_q  <= heat_d;
            light_q <= light_d;
            bell_q  <= bell_d;
            busy_q  <= busy_d;
        end
    end

    assign heat      = heat_q;
    assign light     = light_q;
    assign bell      = bell_q;
    assign busy      = busy_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_mwave_timer_ctrl.sv
// Directed bench for mwave_timer_ctrl with CLK_PER_TICK=4.
module tb_mwave_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst, door, start, cancel;
    logic [7:0] time_in;
    logic [1:0] power_in;
    logic       heat, light, bell, busy;
    logic [7:0] remaining;
`ifdef MWAVE_CHILD_LOCK_EN
    logic       lock_key, locked;
`endif

    int total = 0;
    int bad   = 0;
    logic [3:0] pat;

    always #5 clk = ~clk;

    mwave_timer_ctrl #(
        .TIME_W(8), .CLK_PER_TICK(4), .PWR_W(2), .BELL_TICKS(3), .ADD_SEC(30)
    ) dut (
        .clk(clk), .rst(rst), .door(door), .start(start), .cancel(cancel),
        .time_in(time_in), .power_in(power_in),
`ifdef MWAVE_CHILD_LOCK_EN
        .lock_key(lock_key), .locked(locked),
`endif
        .heat(heat), .light(light), .bell(bell),
        .remaining(remaining), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; door = 1'b0; start = 1'b0; cancel = 1'b0;
        time_in = 8'd0; power_in = 2'd0;
`ifdef MWAVE_CHILD_LOCK_EN
        lock_key = 1'b0;
`endif
        pat = 4'b0011;
        step(); step();
        chk("rst_heat", heat, 0);
        chk("rst_light", light, 0);
        chk("rst_bell", bell, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rem", remaining, 0);
        rst = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // Basic cook: 3 s at full power, then bell
        time_in = 8'd3; power_in = 2'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("c0_busy", busy, 1);
        chk("c0_light", light, 1);
        chk("c0_heat", heat, 1);
        chk("c0_rem", remaining, 3);
        for (int k = 1; k < 12; k++) begin
            step();
            chk("c_heat", heat, 1);
            chk("c_rem", remaining, 3 - k / 4);
        end
        step();
        chk("b0_bell", bell, 1);
        chk("b0_rem", remaining, 0);
        chk("b0_heat", heat, 0);
        chk("b0_busy", busy, 0);
        for (int k = 13; k < 24; k++) begin
            step();
            chk("b_bell", bell, 1);
        end
        step();
        chk("b_end_bell", bell, 0);
        chk("b_end_light", light, 0);

        // Power 1 duty pattern 1,1,0,0
        time_in = 8'd5; power_in = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("duty0", heat, 1);
        for (int k = 1; k < 8; k++) begin
            step();
            chk("duty", heat, 32'(pat[k % 4]));
        end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_rem", remaining, 0);
        chk("cancel_busy", busy, 0);

        // Pause with prescaler at 2, resume
        time_in = 8'd5; power_in = 2'd3; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        door = 1'b1;
        step();
        chk("p_heat", heat, 0);
        chk("p_light", light, 1);
        chk("p_busy", busy, 1);
        chk("p_rem", remaining, 5);
        repeat (19) step();
        chk("p_hold_rem", remaining, 5);
        chk("p_hold_heat", heat, 0);
        door = 1'b0;
        step();
        chk("r_heat", heat, 1);
        chk("r_rem0", remaining, 5);
        step();
        chk("r_rem1", remaining, 5);
        step();
        chk("r_rem2", remaining, 4);
        cancel = 1'b1;
        step();
        cancel = 1'b0;

        // Add-seconds with saturation
        time_in = 8'd240; start = 1'b1;
        step();
        chk("s_rem240", remaining, 240);
        step();
        start = 1'b0;
        chk("s_sat", remaining, 255);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        time_in = 8'd10; start = 1'b1;
        step(); step();
        start = 1'b0;
        chk("s_add", remaining, 40);
        step(); step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s_add_tick", remaining, 69);
        chk("s_add_busy", busy, 1);

        // Cancel in pause with door open, then OPEN ignores start
        door = 1'b1;
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("po_rem", remaining, 0);
        chk("po_light", light, 1);
        chk("po_busy", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("open_start_busy", busy, 0);
        chk("open_light", light, 1);
        door = 1'b0;
        step();
        chk("close_light", light, 0);
        time_in = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_busy", busy, 0);
        chk("zero_rem", remaining, 0);

        // Async reset mid-cook
        time_in = 8'd9; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("pre_rst_heat", heat, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_heat", heat, 0);
        chk("arst_light", light, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rem", remaining, 0);
        #2 rst = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rem", remaining, 0);

`ifdef MWAVE_CHILD_LOCK_EN
        lock_key = 1'b1;
        step();
        lock_key = 1'b0;
        step();
        chk("locked", locked, 1);
        time_in = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("lock_busy", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mwave_timer_ctrl.md
Name: mwave_timer_ctrl

Overview:
- Next-generation microwave oven controller: door/start/cancel FSM with an internal cook-time countdown, replacing the external `finish` strobe.
- Adds a power-level duty cycle on `heat`, pause/resume that keeps the remaining time, a timed bell and a "+N seconds" start-while-cooking feature.
- Sits between the front-panel logic (door switch, buttons, time/power entry) and the magnetron/lamp/buzzer drivers.

Parameters:
- TIME_W, 8: width of cook-time counter in seconds; max time 2^TIME_W-1.
- CLK_PER_TICK, 100: clk cycles per one second tick; must be >=2.
- PWR_W, 2: width of power level; duty period is 2^PWR_W clk cycles.
- BELL_TICKS, 3: bell duration in ticks.
- ADD_SEC, 30: seconds added by `start` pressed during COOK.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- door  in  1  1 = door open (level).
- start  in  1  start request (level, sampled every clk).
- cancel  in  1  cancel request (level).
- time_in  in  TIME_W  cook time in seconds, sampled on accepted start from IDLE.
- power_in  in  PWR_W  power level, sampled on accepted start from IDLE.
- heat  out  1  magnetron enable.
- light  out  1  cavity lamp.
- bell  out  1  buzzer.
- remaining  out  TIME_W  seconds left.
- busy  out  1  1 in COOK or PAUSE.

Behaviour:
- Reset (async, rst=1): state IDLE; remaining=0, prescaler=0, bell counter=0, duty phase=0, latched power=0.
- All outputs are 0 during reset.
- States: IDLE, OPEN, COOK, PAUSE, BELL. One transition per clk; priority in each state as listed.
- IDLE:
  - door -> OPEN.
  - Else start && time_in!=0 -> COOK: remaining<=time_in, power<=power_in, prescaler<=0, phase<=0.
  - start with time_in==0 is ignored.
- OPEN: !door -> IDLE; start/cancel ignored.
- COOK:
  - door -> PAUSE.
  - Else cancel -> IDLE with remaining<=0.
  - Else start -> remaining<=min(remaining+ADD_SEC, 2^TIME_W-1). The sum is computed TIME_W+1 wide and saturates.
  - Prescaler counts 0..CLK_PER_TICK-1. At CLK_PER_TICK-1 (tick) it wraps to 0 and remaining decrements.
  - Tick with remaining==1 -> remaining<=0, go to BELL, bell counter<=0.
  - Start and tick in the same cycle: add and decrement both apply (remaining+ADD_SEC-1, saturating at the max before the decrement), and no BELL is entered.
- PAUSE:
  - Prescaler, phase and remaining hold.
  - cancel -> OPEN if door, else IDLE; remaining<=0.
  - Else !door -> COOK; counting resumes from the held prescaler value.
- BELL:
  - door -> OPEN and bell stops.
  - Prescaler runs. Bell counter increments on each tick; when it reaches BELL_TICKS-1 on a tick -> IDLE.
  - cancel -> IDLE.
  - Bell lasts exactly BELL_TICKS*CLK_PER_TICK cycles if undisturbed.
- Duty phase: PWR_W-bit counter, increments every clk in COOK, wraps freely.
- Outputs are registered: each is the value for the current state, updated on the same edge as the state.
- heat = (state==COOK) && (phase <= power). Power 0 gives 1/2^PWR_W duty; max power gives 100%.
- light = COOK, PAUSE or OPEN.
- bell = BELL.
- busy = COOK or PAUSE.
- remaining = counter value, directly.
- Reset asserted mid-COOK: heat drops asynchronously and remaining clears. No state is retained.

Optional Feature:
- Macro MWAVE_CHILD_LOCK_EN.
- When defined:
  - Extra input port `lock_key` (1 bit).
  - A lock flag toggles on each rising edge of lock_key, detected with a registered previous value. Reset clears the flag.
  - Output port `locked` (1 bit) shows the flag.
  - While locked: start is ignored in every state; cancel still works; door behaviour is unchanged.
- When undefined: neither port exists and start behaves as above.

Test Plan:
- CLK_PER_TICK=4, time_in=3, power_in=3, start 1 clk in IDLE -> COOK; remaining 3,2,1,0 at clks 4,8,12; BELL at clk 12 for 12 clks (BELL_TICKS=3); then IDLE; heat high all 12 COOK clks.
- power_in=1, PWR_W=2 -> heat pattern 1,1,0,0 repeating during COOK.
- COOK with remaining=5 and prescaler=2, door=1 for 20 clks -> PAUSE; remaining stays 5, heat=0, light=1; door=0 -> next decrement 2 clks after resume.
- TIME_W=8, remaining=240, start in COOK -> remaining=255 (saturated); remaining=10 -> 40.
- Cancel in PAUSE with door open -> OPEN, remaining=0; close door -> IDLE. start with time_in=0 in IDLE -> stays IDLE.
- rst pulse mid-COOK (async, between edges) -> heat=light=busy=0 immediately; after release IDLE, remaining=0. With MWAVE_CHILD_LOCK_EN, lock_key pulse then start -> stays IDLE, locked=1.
